// File: rtl/counter_load_arbiter.sv
// Round-robin arbiter that shares one loadable counter's load_en/load port among NREQ requesters.
// Each grant is a single registered load pulse followed by a HOLD-cycle window in which requests are ignored.
module counter_load_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_val,
    output logic                    load_en,
    output logic [WIDTH-1:0]        load,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);
    localparam int OW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_HOLD
    } state_t;

    state_t          state, state_n;
    logic [3:0]      hold_cnt, hold_cnt_n;
    logic [OW-1:0]   ptr, ptr_n;
    logic [OW-1:0]   winner;
    logic            found;

    logic             load_en_n;
    logic [WIDTH-1:0] load_n;
    logic [NREQ-1:0]  gnt_n;
    logic [OW-1:0]    owner_n;
    logic             busy_n;

    // First active request at or above the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found  = 1'b1;
                winner = OW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // Next-state logic: requests are only looked at while IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_n    = state;
        hold_cnt_n = hold_cnt;
        ptr_n      = ptr;
        unique case (state)
            ST_IDLE: begin
                if (found) begin
                    state_n = ST_GRANT;
                    ptr_n   = (winner == OW'(NREQ - 1)) ? '0 : winner + OW'(1);
                end
            end
            ST_GRANT: begin
                if (HOLD == 0) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n    = ST_HOLD;
                    hold_cnt_n = 4'(HOLD);
                end
            end
            ST_HOLD: begin
                if (hold_cnt <= 4'd1) begin
                    state_n = ST_IDLE;
                end else begin
                    hold_cnt_n = hold_cnt - 4'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the state being entered.
    always_comb begin
        load_en_n = 1'b0;
        load_n    = '0;
        gnt_n     = '0;
        owner_n   = owner;
        busy_n    = (state_n != ST_IDLE);
        if (state_n == ST_GRANT) begin
            load_en_n = 1'b1;
            load_n    = req_val[int'(winner)*WIDTH +: WIDTH];
            gnt_n     = NREQ'(1) << winner;
            owner_n   = winner;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            ptr      <= '0;
            load_en  <= 1'b0;
            load     <= '0;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_cnt_n;
            ptr      <= ptr_n;
            load_en  <= load_en_n;
            load     <= load_n;
            gnt      <= gnt_n;
            owner    <= owner_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: doc/counter_load_arbiter.md
Name: counter_load_arbiter

Overview:
Round-robin arbiter that shares the load port (load_en/load) of one loadable up counter between NREQ requesters.
- Each requester presents a load value.
- The arbiter grants one requester at a time and drives a single-cycle load pulse to the counter.
- After each load, a programmable hold window lets the counter run before another load is accepted.
- Sits directly in front of the counter's load_en/load inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, counter/load value width in bits
HOLD, 2, cycles after a grant cycle during which no new grant is issued (0..15)

Ports:
clk  input  1  single clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
req  input  NREQ  level request per requester; held until its gnt bit is seen
req_val  input  NREQ*WIDTH  load values; requester i uses bits [i*WIDTH +: WIDTH]
load_en  output  1  load strobe to the counter; registered
load  output  WIDTH  load value to the counter; registered
gnt  output  NREQ  one-hot grant pulse, coincident with load_en
owner  output  clog2(NREQ)  index of the most recently granted requester
busy  output  1  high in GRANT and HOLD states

Behaviour:
- Reset, sampled on a rising edge: next cycle load_en=0, load=0, gnt=0, owner=0, busy=0, state=IDLE, RR pointer=0 (requester 0 highest priority). Reset overrides everything, including a GRANT or HOLD in progress; the aborted HOLD is discarded.
- States: IDLE, GRANT, HOLD.
- IDLE: if req != 0 at an edge, select the winner, move to GRANT and register the outputs:
  - load_en=1
  - load=req_val[winner]
  - gnt=1<<winner
  - owner=winner
  - busy=1
- If req == 0 in IDLE, stay in IDLE with all outputs low except owner, which holds its value.
- Winner selection: first requester with req=1 scanning from pointer upward, modulo NREQ. After a grant to i, pointer becomes (i+1) mod NREQ.
- GRANT lasts exactly one cycle. load_en and gnt are high only in this cycle.
  - Next state is HOLD with hold counter=HOLD.
  - If HOLD=0, next state is IDLE.
- HOLD: load_en=0, gnt=0, busy=1. Counter decrements each cycle; when it reaches 1, next state is IDLE. HOLD lasts exactly HOLD cycles.
  - Requests are ignored in HOLD: not sampled or latched, and the pointer is unchanged.
- Latency: req high at edge E in IDLE puts load_en high during the cycle after E. The counter loads on the following edge.
- Minimum grant-to-grant spacing: HOLD+2 cycles (GRANT + HOLD + one IDLE sample cycle).
- Value capture: load is latched at the decision edge. Later changes to req_val do not alter the pulse.
- A requester that keeps req high after its gnt is treated as a new request. Because of RR it cannot win twice in a row while others are requesting.
- A requester dropping req during GRANT or HOLD has no effect. A requester dropping req before the IDLE sample is never granted.
- Only one gnt bit is ever set. gnt and load_en are always identical in timing.
- owner persists across IDLE and HOLD until the next grant or reset.

Test Plan:
1. Reset for 2 cycles, then req=0 for 10 cycles -> load_en=0, gnt=0000, busy=0, owner=0 throughout.
2. req=0100, req_val[2]=4'b1100, held until gnt -> one cycle later load_en=1, load=1100, gnt=0100, owner=2. Then busy stays high for 2 more cycles, then IDLE.
3. req=1111 held, values 1,2,3,4 -> grants in order 0,1,2,3,0 with load=1,2,3,4,1. Grants are spaced exactly 4 cycles apart (HOLD=2).
4. Pointer=2 (after granting 1) with req=0011 -> grant goes to 0 (scan 2,3,0), then 1. Requester 1 is not granted twice consecutively.
5. req=0001 asserted only during HOLD and dropped before IDLE -> no grant, load_en stays 0, pointer unchanged.
6. Assert reset in the cycle after GRANT (mid-HOLD) while req=0010 is held -> next cycle busy=0, owner=0, load_en=0. Pointer is 0, so the next grant goes to requester 1 (the only requester) one cycle after reset deasserts plus one sample edge.
